// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding, header/lane geometry,
// memory-map constants and the header range check.
package imem_loader_pkg;

  localparam int PC_SIZE_DEF = 10;
  localparam int HDR_W       = 16;
  localparam int LANES       = 4;
  localparam int LANE_W      = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Words the instruction memory holds for a given address width.
  function automatic logic [31:0] imem_words(
    input int unsigned pc_size
  );
    return 32'd1 << pc_size;
  endfunction

  // A header is usable when 1 <= n <= 2^pc_size.
  function automatic logic hdr_ok(
    input logic [HDR_W-1:0] n,
    input int unsigned      pc_size
  );
    logic [31:0] n_w;
    n_w = {16'd0, n};
    return (n != '0) && (n_w <= imem_words(pc_size));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader bus: byte stream in, instruction-memory write side out.
// slave = loader side, master = host/memory side.
interface imem_loader_if #(
  parameter int PC_SIZE = 10
);
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               rw;
  logic [PC_SIZE-1:0] PC_write;
  logic [31:0]        instruction_in;
  logic               reset_memory;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output rw,
    output PC_write,
    output instruction_in,
    output reset_memory
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  rw,
    input  PC_write,
    input  instruction_in,
    input  reset_memory
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs little-endian payload bytes into 32-bit words
// and keeps a running XOR. Ports: clk, rst_n, clr, take, data -> word,
// word_done (4th byte being taken), xsum.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done,
  output logic [7:0]  xsum
);

  logic [LANE_W-1:0] lane;
  logic [23:0]       sh;

  // Only the three earlier bytes are stored; the top byte of the
  // word is the one on the bus in the completing cycle, so the
  // loader can register the full word without a stall.
  assign word      = {data, sh};
  assign word_done = take &&
                     (lane == LANE_W'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      sh   <= '0;
      xsum <= '0;
    end else if (clr) begin
      lane <= '0;
      sh   <= '0;
      xsum <= '0;
    end else if (take) begin
      lane <= lane + 1'b1;
      sh   <= {data, sh[23:8]};
      xsum <= xsum ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads the instruction memory from a byte stream
// (len header, payload, XOR checksum) while holding the core in reset.
// Ports: clock, reset (async, low), start, bus (imem_loader_if.slave),
// core_reset, done, error.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         core_reset,
  output logic         done,
  output logic         error
);

  state_t state;
  state_t state_n;

  logic               accept;
  logic               take;
  logic               clr;
  logic               word_done;
  logic               sum_ok;
  logic               last_word;
  logic [7:0]         hdr_lo;
  logic [7:0]         xsum;
  logic [31:0]        word;
  logic [HDR_W-1:0]   n_words;
  logic [HDR_W-1:0]   remain;
  logic [PC_SIZE-1:0] addr;

  logic               rw_q;
  logic [PC_SIZE-1:0] pc_q;
  logic [31:0]        instr_q;

  assign bus.byte_ready = (state == S_HDR_LO) ||
                          (state == S_HDR_HI) ||
                          (state == S_DATA)   ||
                          (state == S_CHECK);

  assign accept  = bus.byte_valid && bus.byte_ready;
  assign take    = accept && (state == S_DATA);
  assign clr     = (state == S_CLEAR);
  assign n_words = {bus.byte_data, hdr_lo};
  assign sum_ok  = (bus.byte_data == xsum);

  assign last_word = word_done &&
                     (remain == HDR_W'(1));

  word_assembler u_asm (
    .clk       (clock),
    .rst_n     (reset),
    .clr       (clr),
    .take      (take),
    .data      (bus.byte_data),
    .word      (word),
    .word_done (word_done),
    .xsum      (xsum)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        state_n = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (accept) state_n = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (accept) begin
          if (hdr_ok(n_words, PC_SIZE))
            state_n = S_DATA;
          else
            state_n = S_ERROR;
        end
      end
      S_DATA: begin
        if (last_word) state_n = S_CHECK;
      end
      S_CHECK: begin
        if (accept) begin
          if (sum_ok) state_n = S_DONE;
          else        state_n = S_ERROR;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Header low byte, word countdown and write address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hdr_lo <= '0;
      remain <= '0;
      addr   <= '0;
    end else begin
      if (clr) begin
        addr <= '0;
      end else if (word_done) begin
        addr <= addr + 1'b1;
      end
      if (accept && state == S_HDR_LO) begin
        hdr_lo <= bus.byte_data;
      end
      if (accept && state == S_HDR_HI) begin
        remain <= n_words;
      end else if (word_done) begin
        remain <= remain - 1'b1;
      end
    end
  end

  // Write port is its own register stage, so the last pulse
  // lands even while the FSM is already in CHECK.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rw_q    <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      rw_q <= word_done;
      if (word_done) begin
        pc_q    <= addr;
        instr_q <= word;
      end
    end
  end

  assign bus.rw             = rw_q;
  assign bus.PC_write       = pc_q;
  assign bus.instruction_in = instr_q;
  assign bus.reset_memory   = clr;

  assign core_reset = (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for imem_loader with
// hand-computed words, addresses and checksums.
module tb_imem_loader;

  localparam int PC_SIZE = 10;

  logic clock;
  logic reset;
  logic start;
  logic core_reset;
  logic done;
  logic error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PC_SIZE-1:0] pcq[$];
  logic [31:0]        wdq[$];

  imem_loader_if #(.PC_SIZE(PC_SIZE)) bus ();

  imem_loader #(.PC_SIZE(PC_SIZE)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.rw === 1'b1) begin
      pcq.push_back(bus.PC_write);
      wdq.push_back(bus.instruction_in);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h",
               tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the
  // accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (g >= 50) check("byte_ready_to", bus.byte_ready, 1);
    @(negedge clock);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_clr1"}, bus.reset_memory, 1);
    check({tag, "_rdy0"}, bus.byte_ready, 0);
    @(negedge clock);
    check({tag, "_clr0"}, bus.reset_memory, 0);
    check({tag, "_rdy1"}, bus.byte_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, bus.byte_ready, 0);
    check({tag, "_rw"}, bus.rw, 0);
    check({tag, "_pc"}, bus.PC_write, 0);
    check({tag, "_ins"}, bus.instruction_in, 0);
    check({tag, "_rmem"}, bus.reset_memory, 0);
    check({tag, "_crst"}, core_reset, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, error, 0);
  endtask

  logic [31:0] w;
  logic [7:0]  xs;
  int          bad;

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clock);

    // Bytes offered in IDLE must not be consumed.
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    repeat (3) @(negedge clock);
    check("idle_rdy", bus.byte_ready, 0);
    bus.byte_valid = 1'b0;

    // N=2, good checksum, with a stray start mid-data.
    do_start("t1");
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h44332211);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_word(32'h88776655);
    send_byte(8'h88);
    check("t1_done", done, 1);
    check("t1_err", error, 0);
    check("t1_crst", core_reset, 0);
    check("t1_nwr", pcq.size(), 2);
    if (pcq.size() == 2) begin
      check("t1_pc0", pcq[0], 0);
      check("t1_w0", wdq[0], 32'h44332211);
      check("t1_pc1", pcq[1], 1);
      check("t1_w1", wdq[1], 32'h88776655);
    end
    check("t1_hold_pc", bus.PC_write, 1);
    check("t1_hold_ins", bus.instruction_in, 32'h88776655);
    pcq.delete();
    wdq.delete();

    // Same stream, wrong checksum.
    do_start("t2");
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h44332211);
    send_word(32'h88776655);
    send_byte(8'h00);
    check("t2_err", error, 1);
    check("t2_done", done, 0);
    check("t2_crst", core_reset, 1);
    check("t2_nwr", pcq.size(), 2);
    pcq.delete();
    wdq.delete();

    // Header 0.
    do_start("t3");
    send_byte(8'h00);
    send_byte(8'h00);
    check("t3_err", error, 1);
    check("t3_rdy", bus.byte_ready, 0);
    repeat (2) @(negedge clock);
    check("t3_nwr", pcq.size(), 0);

    // Header 1025.
    do_start("t4");
    send_byte(8'h01);
    send_byte(8'h04);
    check("t4_err", error, 1);
    check("t4_done", done, 0);
    repeat (2) @(negedge clock);
    check("t4_nwr", pcq.size(), 0);

    // N=1 with gaps between bytes; de^ad^be^ef = 22.
    do_start("t5");
    send_byte(8'h01);
    @(negedge clock);
    send_byte(8'h00);
    @(negedge clock);
    send_byte(8'hDE);
    @(negedge clock);
    send_byte(8'hAD);
    @(negedge clock);
    send_byte(8'hBE);
    @(negedge clock);
    send_byte(8'hEF);
    @(negedge clock);
    send_byte(8'h22);
    check("t5_done", done, 1);
    check("t5_nwr", pcq.size(), 1);
    if (pcq.size() == 1) begin
      check("t5_pc", pcq[0], 0);
      check("t5_w", wdq[0], 32'hEFBEADDE);
    end
    pcq.delete();
    wdq.delete();

    // Reset after 5 payload bytes, then a fresh load.
    do_start("t6");
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'hA3A2A1A0);
    send_byte(8'hA4);
    reset = 1'b0;
    #1;
    check_reset_vals("t6_mid");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pcq.delete();
    wdq.delete();
    do_start("t6b");
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h04030201);
    send_byte(8'h04);
    check("t6_done", done, 1);
    check("t6_nwr", pcq.size(), 1);
    if (pcq.size() == 1) begin
      check("t6_w", wdq[0], 32'h04030201);
    end
    pcq.delete();
    wdq.delete();

    // Full memory, back-to-back bytes.
    do_start("t7");
    send_byte(8'h00);
    send_byte(8'h04);
    xs = 8'h00;
    for (int k = 0; k < 1024; k++) begin
      w  = k * 32'h9E3779B1 + 32'h01234567;
      xs = xs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      send_word(w);
    end
    check("t7_crst_busy", core_reset, 1);
    send_byte(xs);
    check("t7_done", done, 1);
    check("t7_crst", core_reset, 0);
    check("t7_nwr", pcq.size(), 1024);
    bad = 0;
    for (int k = 0; k < pcq.size(); k++) begin
      w = k * 32'h9E3779B1 + 32'h01234567;
      if (pcq[k] != PC_SIZE'(k) || wdq[k] != w) bad++;
    end
    check("t7_words", bad, 0);
    check("t7_last_pc", bus.PC_write, 10'h3FF);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
